// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Registered data-bus request as presented on the bus ports.
  typedef struct packed {
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational legality check, store lane formatting and load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        illegal_c,
  output logic [3:0]  wstrb_c,
  output logic [31:0] wdata_c,
  output logic [31:0] rdata_c
);

  logic        f3_ok;
  logic        misaligned;
  logic [31:0] shifted;

  // Unsigned variants exist only for loads; funct3[1:0] selects access size.
  always_comb begin
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !we;
      default:          f3_ok = 1'b0;
    endcase
    if (funct3[1:0] == 2'b01) begin
      misaligned = addr_lo[0];
    end else if (funct3[1:0] == 2'b10) begin
      misaligned = |addr_lo;
    end
    illegal_c = !f3_ok || misaligned;
  end

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        wdata_c = {4{wdata[7:0]}};
        wstrb_c = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata_c = {2{wdata[15:0]}};
        wstrb_c = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   wstrb_c = 4'b1111;
      default: wstrb_c = 4'b0000;
    endcase
  end

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    rdata_c = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata_c = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata_c = {24'd0, shifted[7:0]};
      F3_HU:   rdata_c = {16'd0, shifted[15:0]};
      default: rdata_c = rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request, runs it on the word bus, returns one response.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] bus_addr,
  output logic        bus_re,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  lsu_state_t       state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  bus_req_t         bus_q, bus_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_rdata_q, resp_rdata_d;
  logic             resp_error_q, resp_error_d;
  logic             req_ready_q, req_ready_d;

  logic             accept_c;
  logic             timeout_c;
  logic [2:0]       al_f3_c;
  logic [1:0]       al_off_c;
  logic             illegal_c;
  logic [3:0]       wstrb_c;
  logic [31:0]      wdata_c;
  logic [31:0]      load_c;

  // Formatter sees the live request while idle and the captured one afterwards.
  always_comb begin
    al_f3_c  = (state_q == LSU_IDLE) ? req_funct3 : f3_q;
    al_off_c = (state_q == LSU_IDLE) ? req_addr[1:0] : off_q;
  end

  lsu_align u_align (
    .we        (req_we),
    .funct3    (al_f3_c),
    .addr_lo   (al_off_c),
    .wdata     (req_wdata),
    .rdata     (bus_rdata),
    .illegal_c (illegal_c),
    .wstrb_c   (wstrb_c),
    .wdata_c   (wdata_c),
    .rdata_c   (load_c)
  );

  assign accept_c  = req_valid && req_ready_q;
  assign timeout_c = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= LSU_IDLE;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      cnt_q        <= '0;
      bus_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
      req_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      req_ready_q  <= req_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (accept_c) state_d = illegal_c ? LSU_RESP : LSU_BUS;
      LSU_BUS:  if (bus_ack || timeout_c) state_d = LSU_RESP;
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // An ack on the final allowed cycle takes priority over the timeout.
  always_comb begin
    f3_d         = f3_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;
    req_ready_d  = (state_d == LSU_IDLE);
    case (state_q)
      LSU_IDLE: begin
        if (accept_c) begin
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          cnt_d = '0;
          if (illegal_c) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            bus_d.addr  = {req_addr[31:2], 2'b00};
            bus_d.re    = !req_we;
            bus_d.we    = req_we;
            bus_d.wstrb = req_we ? wstrb_c : 4'b0000;
            bus_d.wdata = req_we ? wdata_c : 32'd0;
          end
        end
      end
      LSU_BUS: begin
        if (bus_ack) begin
          bus_d        = '0;
          resp_valid_d = 1'b1;
          resp_rdata_d = bus_q.we ? 32'd0 : load_c;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (timeout_c) begin
            bus_d        = '0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign bus_addr   = bus_q.addr;
  assign bus_re     = bus_q.re;
  assign bus_we     = bus_q.we;
  assign bus_wstrb  = bus_q.wstrb;
  assign bus_wdata  = bus_q.wdata;

endmodule
